ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//   Pointer/flag controller that drives our 64x8 single-port RAM (registered read address) as a FIFO.
//   Sits directly upstream of the RAM: generates we_in, write_addr and read_addr from push/pop requests.
//   Producer data goes straight to the RAM data_in; consumer takes RAM data_out, qualified by rd_valid.
//   Tracks occupancy and full/empty/almost-full, and latches sticky overflow/underflow error flags.
// PARAMETERS
//   ADDR_W    6    RAM address width; DEPTH = 2**ADDR_W entries (64).
//   AFULL_LVL 56   almost_full asserted when count >= AFULL_LVL (valid range 1..DEPTH).
// PORTS
//   clk         in   1         rising-edge clock, shared with the RAM.
//   rst         in   1         asynchronous, active-high reset.
//   push        in   1         producer write request; RAM data_in must be valid the same cycle.
//   pop         in   1         consumer read request.
//   clr_err     in   1         synchronous clear of overflow/underflow.
//   we_out      out  1         to RAM we_in.
//   write_addr  out  ADDR_W    to RAM write_addr (current write pointer).
//   read_addr   out  ADDR_W    to RAM read_addr (current read pointer).
//   rd_valid    out  1         RAM data_out holds the popped word this cycle.
//   full        out  1         count == DEPTH.
//   empty       out  1         count == 0.
//   almost_full out  1         count >= AFULL_LVL.
//   count       out  ADDR_W+1  occupancy, 0..DEPTH.
//   overflow    out  1         sticky: push seen while full.
//   underflow   out  1         sticky: pop seen while empty.
// BEHAVIOUR
//   Reset (async, any cycle): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0.
//     Result: empty=1, full=0, almost_full=0, we_out=0. RAM contents are not cleared.
//   Accept rules, evaluated on the registered state at each cycle:
//     push_ok = push & ~full;  pop_ok = pop & ~empty.
//   Outputs are combinational from the registered state:
//     we_out = push_ok; write_addr = wr_ptr; read_addr = rd_ptr.
//   On the edge:
//     push_ok: wr_ptr += 1.
//     pop_ok: rd_ptr += 1.
//     count: +1 on push only, -1 on pop only, unchanged when both are accepted.
//     Pointers wrap modulo DEPTH (63 -> 0) with no special handling.
//   Read latency is 1 cycle.
//     The RAM registers read_addr on the pop edge, so data_out is valid the following cycle.
//     rd_valid <= pop_ok, so it is high in exactly that cycle.
//     Back-to-back pops give one word per cycle, with rd_valid held high.
//   Simultaneous push and pop:
//     Not full and not empty: both accepted.
//     Empty: push accepted, pop rejected.
//       underflow is set; the new word becomes poppable next cycle.
//     Full: pop accepted, push rejected, overflow is set.
//       A push on a full FIFO is never accepted, even with a same-cycle pop: the write slot equals the read slot, and the RAM would return the overwritten data.
//   Count 1 with pop and push: both accepted.
//     The slots differ (wr_ptr = rd_ptr + 1), so the popped word is intact.
//   Error flags:
//     overflow  <= overflow  | (push & full).
//     underflow <= underflow | (pop & empty).
//     clr_err clears both; a new error in the same cycle as clr_err wins (flag set).
//   Rejected requests have no effect on pointers, count or we_out.
//   Reset asserted mid-stream: state returns to empty immediately; rd_valid drops asynchronously.
// TESTING
//   1. Reset, push 0x11,0x22,0x33 on 3 cycles, then pop 3 cycles -> rd_valid high on 3 cycles, each 1 cycle after its pop; data 0x11,0x22,0x33; count 3->0; empty=1.
//   2. Push 64 words (i=0..63) -> full=1 at count 64, almost_full from count 56; 65th push -> we_out=0, overflow=1, count stays 64.
//   3. Full FIFO, push+pop same cycle -> pop ok, push rejected, count 63, overflow=1; next cycle data_out=0x00 (the oldest word, not the new one).
//   4. Empty FIFO, pop -> rd_valid stays 0, underflow=1; then clr_err -> underflow=0; clr_err+pop on empty -> underflow stays 1.
//   5. Stream 200 words with push&pop every cycle after priming 1 word -> write_addr/read_addr wrap 63->0; every word matches in order; count stays 1.
//   6. Assert rst while count=10 and a pop is in flight -> rd_valid=0, count=0, empty=1 immediately; next push writes address 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Pointer/flag controller that runs a single-port RAM with a
//               registered read address as a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int AFULL_LVL = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic              we_out,
    output logic [ADDR_W-1:0] write_addr,
    output logic [ADDR_W-1:0] read_addr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_AFULL   = AFULL_LVL[ADDR_W:0];
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    // A push into a full FIFO is refused even alongside a pop: both would hit the same slot.
    assign w_push_ok = push & ~w_full;
    assign w_pop_ok  = pop & ~w_empty;

    assign we_out      = w_push_ok;
    assign write_addr  = r_wr_ptr;
    assign read_addr   = r_rd_ptr;
    assign rd_valid    = r_rd_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_AFULL);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // RAM latches read_addr on this edge, so its data_out is valid next cycle.
            r_rd_valid <= w_pop_ok;
            // A fresh error outranks a same-cycle clear.
            if (push & w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Self-checking bench for ram_fifo_ctrl with a 64x8 RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic       we_out;
    logic [5:0] write_addr;
    logic [5:0] read_addr;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] mem [64];
    logic [5:0] r_raddr;

    int n_vec;
    int n_err;

    logic       we_pre;
    logic [5:0] wa_pre;
    logic [5:0] ra_pre;

    ram_fifo_ctrl #(.ADDR_W(6), .AFULL_LVL(56)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .we_out      (we_out),
        .write_addr  (write_addr),
        .read_addr   (read_addr),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read address.
    always @(posedge clk) begin
        if (we_out) mem[write_addr] <= data_in;
        r_raddr <= read_addr;
    end
    assign data_out = mem[r_raddr];

    typedef struct {
        logic       p;
        logic       q;
        logic       c;
        logic [7:0] d;
        logic       we;
        logic [6:0] cnt;
        logic       rdv;
        logic [7:0] dout;
        logic       emp;
        logic       uf;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic p, input logic q, input logic c, input logic [7:0] d,
                                input logic we, input logic [6:0] cnt, input logic rdv,
                                input logic [7:0] dout, input logic emp, input logic uf);
        vec_t v;
        v.p = p; v.q = q; v.c = c; v.d = d; v.we = we; v.cnt = cnt;
        v.rdv = rdv; v.dout = dout; v.emp = emp; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Drive one cycle; capture the combinational outputs before the edge, return 1ns after it.
    task automatic cyc(input logic p, input logic q, input logic c, input logic [7:0] d);
        push = p; pop = q; clr_err = c; data_in = d;
        #1;
        we_pre = we_out; wa_pre = write_addr; ra_pre = read_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int   wwrap;
        int   rwrap;
        logic [5:0] pw;
        logic [5:0] pr;

        n_vec = 0; n_err = 0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00; rst = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        // push 3, pop 3, then underflow / clear handling on an empty FIFO
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 7'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 7'd2, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 7'd3, 1'b0, 8'h00, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'd2, 1'b1, 8'h11, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'd1, 1'b1, 8'h22, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b1, 8'h33, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 7'd1, 1'b0, 8'h00, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b1, 8'h44, 1'b1, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 7'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_afull", int'(almost_full), 0);
        chk("rst_we", int'(we_out), 0);
        chk("rst_rdv", int'(rd_valid), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);
        chk("rst_waddr", int'(write_addr), 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].p, tbl[i].q, tbl[i].c, tbl[i].d);
            chk($sformatf("v%0d_we", i), int'(we_pre), int'(tbl[i].we));
            chk($sformatf("v%0d_count", i), int'(count), int'(tbl[i].cnt));
            chk($sformatf("v%0d_rdv", i), int'(rd_valid), int'(tbl[i].rdv));
            chk($sformatf("v%0d_empty", i), int'(empty), int'(tbl[i].emp));
            chk($sformatf("v%0d_udf", i), int'(underflow), int'(tbl[i].uf));
            chk($sformatf("v%0d_ovf", i), int'(overflow), 0);
            if (tbl[i].rdv) chk($sformatf("v%0d_dout", i), int'(data_out), int'(tbl[i].dout));
        end

        // fill to full, almost_full threshold, overflow
        do_reset();
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            chk("fill_we", int'(we_pre), 1);
            chk("fill_count", int'(count), i + 1);
            chk("fill_afull", int'(almost_full), (i + 1 >= 56) ? 1 : 0);
            chk("fill_full", int'(full), (i == 63) ? 1 : 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'hEE);
        chk("ovf_we", int'(we_pre), 0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 64);

        // full: push+pop -> only pop accepted, oldest word returned
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf_clr", int'(overflow), 0);
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("fullpp_we", int'(we_pre), 0);
        chk("fullpp_count", int'(count), 63);
        chk("fullpp_ovf", int'(overflow), 1);
        chk("fullpp_rdv", int'(rd_valid), 1);
        chk("fullpp_dout", int'(data_out), 0);
        chk("fullpp_full", int'(full), 0);

        // streaming with occupancy 1 across pointer wrap
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        wwrap = 0; rwrap = 0; pw = wa_pre; pr = ra_pre;
        for (int k = 1; k <= 200; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(k));
            if (pw == 6'd63 && wa_pre == 6'd0) wwrap++;
            if (pr == 6'd63 && ra_pre == 6'd0) rwrap++;
            pw = wa_pre; pr = ra_pre;
            chk("strm_we", int'(we_pre), 1);
            chk("strm_rdv", int'(rd_valid), 1);
            chk("strm_dout", int'(data_out), (k - 1) & 8'hFF);
            chk("strm_count", int'(count), 1);
        end
        chk("strm_wwrap", wwrap, 3);
        chk("strm_rwrap", rwrap, 3);

        // reset mid-stream with a pop in flight
        do_reset();
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i + 8'h50));
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("mid_count", int'(count), 10);
        chk("mid_rdv", int'(rd_valid), 1);
        chk("mid_dout", int'(data_out), 8'h50);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rdv", int'(rd_valid), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h99);
        chk("arst_waddr", int'(wa_pre), 0);
        chk("arst_we", int'(we_pre), 1);
        chk("arst_count1", int'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
